// File: rtl/add_fu_ctrl.sv
// add_fu_ctrl: scoreboard-managed integer add/sub functional unit.
// Accepts one instruction at a time, counts a fixed execution latency,
// then holds the (WIDTH+1)-bit result and its destination tag until the
// scoreboard grants write-back. flush kills any in-flight or held result.
module add_fu_ctrl #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic             issue_op,
  input  logic [WIDTH-1:0] issue_a,
  input  logic [WIDTH-1:0] issue_b,
  input  logic [TAG_W-1:0] issue_dest,
  output logic             busy,
  output logic             wb_req,
  output logic [WIDTH:0]   wb_data,
  output logic [TAG_W-1:0] wb_dest,
  input  logic             wb_grant,
  input  logic             flush
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] EXEC    = 2'd1;
  localparam logic [1:0] WB_WAIT = 2'd2;

  // Counter is sized for the full legal latency range (1..15).
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  logic [1:0]       state;
  logic [3:0]       cnt;
  logic             op_p0;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic [TAG_W-1:0] dest_p0;

  // Zero-extended add, or two's-complement subtract where the top bit is
  // the carry-out (1 = no borrow, a >= b).
  function automatic logic [WIDTH:0] alu_result(input logic op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH:0] ext_a;
    logic [WIDTH:0] ext_b;
    ext_a = {1'b0, a};
    if (op) begin
      ext_b = {1'b0, ~b};
      return ext_a + ext_b + (WIDTH+1)'(1);
    end
    ext_b = {1'b0, b};
    return ext_a + ext_b;
  endfunction

  assign issue_ready = (state == IDLE) && !flush;
  assign busy        = (state != IDLE);

  // Control FSM, operand latch (stage p0) and result register; rst beats
  // flush, flush beats every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      op_p0   <= 1'b0;
      a_p0    <= '0;
      b_p0    <= '0;
      dest_p0 <= '0;
      wb_req  <= 1'b0;
      wb_data <= '0;
      wb_dest <= '0;
    end else if (flush) begin
      state  <= IDLE;
      wb_req <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue_valid) begin
            op_p0   <= issue_op;
            a_p0    <= issue_a;
            b_p0    <= issue_b;
            dest_p0 <= issue_dest;
            cnt     <= LAT_M1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            wb_data <= alu_result(op_p0, a_p0, b_p0);
            wb_dest <= dest_p0;
            wb_req  <= 1'b1;
            state   <= WB_WAIT;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WB_WAIT: begin
          if (wb_grant) begin
            wb_req <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          wb_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_fu_ctrl.sv
// Directed testbench for add_fu_ctrl (LATENCY=2 main unit, LATENCY=1 unit).
module tb_add_fu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;

  logic        issue_valid, issue_op, wb_grant;
  logic [15:0] issue_a, issue_b;
  logic [2:0]  issue_dest;
  logic        issue_ready, busy, wb_req;
  logic [16:0] wb_data;
  logic [2:0]  wb_dest;

  logic        l1_valid, l1_op, l1_grant;
  logic [15:0] l1_a, l1_b;
  logic [2:0]  l1_dest;
  logic        l1_ready, l1_busy, l1_req;
  logic [16:0] l1_data;
  logic [2:0]  l1_wdest;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  add_fu_ctrl #(.WIDTH(16), .LATENCY(2), .TAG_W(3)) u_dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_a(issue_a), .issue_b(issue_b),
    .issue_dest(issue_dest), .busy(busy), .wb_req(wb_req), .wb_data(wb_data),
    .wb_dest(wb_dest), .wb_grant(wb_grant), .flush(flush)
  );

  add_fu_ctrl #(.WIDTH(16), .LATENCY(1), .TAG_W(3)) u_dut_l1 (
    .clk(clk), .rst(rst), .issue_valid(l1_valid), .issue_ready(l1_ready),
    .issue_op(l1_op), .issue_a(l1_a), .issue_b(l1_b),
    .issue_dest(l1_dest), .busy(l1_busy), .wb_req(l1_req), .wb_data(l1_data),
    .wb_dest(l1_wdest), .wb_grant(l1_grant), .flush(flush)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic op, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] dest);
    issue_valid = 1'b1;
    issue_op    = op;
    issue_a     = a;
    issue_b     = b;
    issue_dest  = dest;
  endtask

  // Accept one op with grant held high; expects result two edges later,
  // release on the following edge.
  task automatic run_op(input string tag, input logic op, input logic [15:0] a,
                        input logic [15:0] b, input logic [2:0] dest,
                        input logic [16:0] exp_data);
    wb_grant = 1'b1;
    issue(op, a, b, dest);
    chk({tag, "_ready_pre"}, 32'(issue_ready), 32'd1);
    tick();                                 // E0: accept
    issue_valid = 1'b0;
    chk({tag, "_busy_e0"}, 32'(busy), 32'd1);
    chk({tag, "_req_e0"}, 32'(wb_req), 32'd0);
    tick();                                 // E1
    chk({tag, "_busy_e1"}, 32'(busy), 32'd1);
    chk({tag, "_req_e1"}, 32'(wb_req), 32'd0);
    tick();                                 // E2: result valid
    chk({tag, "_busy_e2"}, 32'(busy), 32'd1);
    chk({tag, "_req_e2"}, 32'(wb_req), 32'd1);
    chk({tag, "_data"}, 32'(wb_data), 32'(exp_data));
    chk({tag, "_dest"}, 32'(wb_dest), 32'(dest));
    chk({tag, "_ready_wb"}, 32'(issue_ready), 32'd0);
    tick();                                 // E3: grant edge
    chk({tag, "_req_e3"}, 32'(wb_req), 32'd0);
    chk({tag, "_busy_e3"}, 32'(busy), 32'd0);
    chk({tag, "_ready_e3"}, 32'(issue_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    issue_valid = 1'b0; issue_op = 1'b0; issue_a = '0; issue_b = '0;
    issue_dest = '0; wb_grant = 1'b0;
    l1_valid = 1'b0; l1_op = 1'b0; l1_a = '0; l1_b = '0; l1_dest = '0;
    l1_grant = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_req", 32'(wb_req), 32'd0);
    chk("rst_data", 32'(wb_data), 32'd0);
    chk("rst_dest", 32'(wb_dest), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(issue_ready), 32'd1);

    // ADD with carry-out, then SUB both directions
    run_op("add_ffff_1", 1'b0, 16'hFFFF, 16'h0001, 3'd5, 17'h10000);
    run_op("sub_5_3", 1'b1, 16'd5, 16'd3, 3'd1, 17'h10002);
    run_op("sub_3_5", 1'b1, 16'd3, 16'd5, 3'd2, 17'h0FFFE);

    // Held result while grant stays low; pending issue must wait
    wb_grant = 1'b0;
    issue(1'b0, 16'h1234, 16'h4321, 3'd2);
    tick();                                 // accept
    issue(1'b0, 16'h1111, 16'h1111, 3'd7);
    tick();
    tick();
    chk("hold_req_rise", 32'(wb_req), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("hold_req_%0d", i), 32'(wb_req), 32'd1);
      chk($sformatf("hold_data_%0d", i), 32'(wb_data), 32'h05555);
      chk($sformatf("hold_dest_%0d", i), 32'(wb_dest), 32'd2);
      chk($sformatf("hold_ready_%0d", i), 32'(issue_ready), 32'd0);
    end
    wb_grant = 1'b1;
    tick();                                 // grant edge
    wb_grant = 1'b0;
    chk("hold_req_fall", 32'(wb_req), 32'd0);
    chk("hold_busy_fall", 32'(busy), 32'd0);
    tick();                                 // pending issue accepted now
    issue_valid = 1'b0;
    chk("pend_busy", 32'(busy), 32'd1);
    tick();
    tick();
    chk("pend_req", 32'(wb_req), 32'd1);
    chk("pend_data", 32'(wb_data), 32'h02222);
    chk("pend_dest", 32'(wb_dest), 32'd7);
    wb_grant = 1'b1;
    tick();
    chk("pend_req_fall", 32'(wb_req), 32'd0);

    // flush during EXEC
    issue(1'b0, 16'd9, 16'd9, 3'd1);
    tick();
    issue_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fexec_busy", 32'(busy), 32'd0);
    chk("fexec_req", 32'(wb_req), 32'd0);
    tick();
    tick();
    chk("fexec_req_late", 32'(wb_req), 32'd0);
    run_op("add_1_1", 1'b0, 16'd1, 16'd1, 3'd4, 17'h00002);

    // flush together with grant in WB_WAIT
    wb_grant = 1'b0;
    issue(1'b0, 16'd2, 16'd3, 3'd3);
    tick();
    issue_valid = 1'b0;
    tick();
    tick();
    chk("fwb_req_pre", 32'(wb_req), 32'd1);
    chk("fwb_data_pre", 32'(wb_data), 32'h00005);
    flush = 1'b1;
    wb_grant = 1'b1;
    tick();
    flush = 1'b0;
    wb_grant = 1'b0;
    chk("fwb_req", 32'(wb_req), 32'd0);
    chk("fwb_busy", 32'(busy), 32'd0);
    tick();
    chk("fwb_req_late", 32'(wb_req), 32'd0);

    // flush together with issue in IDLE
    flush = 1'b1;
    issue(1'b0, 16'd4, 16'd4, 3'd6);
    #1;
    chk("fidle_ready", 32'(issue_ready), 32'd0);
    tick();
    flush = 1'b0;
    issue_valid = 1'b0;
    chk("fidle_busy", 32'(busy), 32'd0);
    #1;
    chk("fidle_ready_after", 32'(issue_ready), 32'd1);

    // rst mid-EXEC
    wb_grant = 1'b1;
    issue(1'b0, 16'd7, 16'd8, 3'd6);
    tick();
    issue_valid = 1'b0;
    chk("rexec_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rexec_busy", 32'(busy), 32'd0);
    chk("rexec_req", 32'(wb_req), 32'd0);
    chk("rexec_data", 32'(wb_data), 32'd0);
    chk("rexec_dest", 32'(wb_dest), 32'd0);
    tick();
    tick();
    chk("rexec_req_late", 32'(wb_req), 32'd0);
    chk("rexec_ready", 32'(issue_ready), 32'd1);
    wb_grant = 1'b0;

    // LATENCY=1 unit
    l1_grant = 1'b1;
    l1_valid = 1'b1; l1_op = 1'b0; l1_a = 16'h8000; l1_b = 16'h8000; l1_dest = 3'd4;
    chk("l1_ready", 32'(l1_ready), 32'd1);
    tick();
    l1_valid = 1'b0;
    chk("l1_busy_e0", 32'(l1_busy), 32'd1);
    chk("l1_req_e0", 32'(l1_req), 32'd0);
    tick();
    chk("l1_req_e1", 32'(l1_req), 32'd1);
    chk("l1_data", 32'(l1_data), 32'h10000);
    chk("l1_dest", 32'(l1_wdest), 32'd4);
    tick();
    chk("l1_req_e2", 32'(l1_req), 32'd0);
    chk("l1_busy_e2", 32'(l1_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
